// File: rtl/seven_seg_scan_driver.sv
// Multiplexed seven-segment scan driver: double-buffered digit capture, leading-zero
// blanking, anti-ghost anode blanking and registered active-low outputs.
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 2,
    parameter int HEX_MODE    = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    en,
    input  logic                    blank_lz,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_done,
    output logic                    load_pending
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
    localparam logic [6:0]    SEG_OFF   = 7'h7F;

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] disp_digits, pend_digits;
    logic [NUM_DIGITS-1:0]   disp_dp, pend_dp;
    logic                    cnt_wrap, frame_wrap;
    logic [3:0]              sel_nib;
    logic                    sel_dp, sel_blank, zero_run;
    logic [NUM_DIGITS-1:0]   an_next;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] glyph;
        unique case (nib)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            4'hF: glyph = 7'b0001110;
        endcase
        if (HEX_MODE == 0 && nib > 4'd9) glyph = SEG_OFF;
        return glyph;
    endfunction

    assign cnt_wrap   = en && (cnt == CNT_LAST);
    assign frame_wrap = cnt_wrap && (idx == IDX_LAST);

    // Walk from the most significant digit down so zero_run tells whether the
    // selected digit and everything above it are zero.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        sel_nib   = 4'd0;
        sel_dp    = 1'b0;
        sel_blank = 1'b0;
        zero_run  = 1'b1;
        an_next   = '1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            // NOTE: blocking assignments here, so zero_run accumulates within one evaluation.
            zero_run = zero_run && (disp_digits[4*i +: 4] == 4'd0);
            if (IW'(i) == idx) begin
                sel_nib   = disp_digits[4*i +: 4];
                sel_dp    = disp_dp[i];
                sel_blank = blank_lz && zero_run && (i != 0);
                an_next[i] = (cnt < CNT_BLANK);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: display and pending buffers are cleared too, so the first frame shows zeros.
            cnt          <= '0;
            idx          <= '0;
            disp_digits  <= '0;
            disp_dp      <= '0;
            pend_digits  <= '0;
            pend_dp      <= '0;
            load_pending <= 1'b0;
            frame_done   <= 1'b0;
            an           <= '1;
            seg          <= SEG_OFF;
            dp           <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments for all state, so every register samples pre-edge values.
            frame_done <= frame_wrap;
            if (en) begin
                cnt <= cnt_wrap ? '0 : cnt + 1'b1;
                if (cnt_wrap) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                an  <= an_next;
                seg <= sel_blank ? SEG_OFF : decode(sel_nib);
                dp  <= ~sel_dp;
            end else begin
                an  <= '1;
                seg <= SEG_OFF;
                dp  <= 1'b1;
            end

            // Commit reads the old pending value, so a load on the wrap cycle lands in the next frame.
            if (frame_wrap && load_pending) begin
                disp_digits <= pend_digits;
                disp_dp     <= pend_dp;
            end
            if (load) begin
                pend_digits  <= digits_in;
                pend_dp      <= dp_in;
                load_pending <= 1'b1;
            end else if (frame_wrap) begin
                load_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver (4 digits, 4 clocks per slot, 1 blank clock),
// running decimal and hex-glyph instances side by side on the same stimulus.
module tb_seven_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst, load, en, blank_lz;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  an0, an1;
    logic [6:0]  seg0, seg1;
    logic        dp0, dp1, fd0, fd1, lp0, lp1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    seven_seg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYC(1), .HEX_MODE(0)) dut (
        .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in), .load(load), .en(en),
        .blank_lz(blank_lz), .an(an0), .seg(seg0), .dp(dp0), .frame_done(fd0),
        .load_pending(lp0)
    );

    seven_seg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYC(1), .HEX_MODE(1)) dut_hex (
        .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in), .load(load), .en(en),
        .blank_lz(blank_lz), .an(an1), .seg(seg1), .dp(dp1), .frame_done(fd1),
        .load_pending(lp1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " an"}, an0, 4'hF);
        check({tag, " seg"}, seg0, 7'h7F);
        check({tag, " seg hex"}, seg1, 7'h7F);
        check({tag, " dp"}, dp0, 1'b1);
        check({tag, " frame_done"}, fd0, 1'b0);
        check({tag, " load_pending"}, lp0, 1'b0);
        check({tag, " load_pending hex"}, lp1, 1'b0);
    endtask

    // One aligned 16-cycle frame; expected glyphs packed {d3,d2,d1,d0}, up to three loads
    // at frame cycles la/lb/lc (0 = unused).
    task automatic run_frame(input string name,
                             input logic [27:0] exp_dec, input logic [27:0] exp_hex,
                             input logic [3:0] exp_dp_n,
                             input int la, input logic [15:0] va,
                             input int lb, input logic [15:0] vb,
                             input int lc, input logic [15:0] vc,
                             input logic [3:0] ldp);
        for (int e = 1; e <= 16; e++) begin
            int st, c, d;
            logic [3:0] ea;
            load  = (e == la) || (e == lb) || (e == lc);
            dp_in = ldp;
            digits_in = (e == la) ? va : (e == lb) ? vb : vc;
            step();
            st = e - 1;
            c  = st % 4;
            d  = st / 4;
            ea = (c == 0) ? 4'hF : ~(4'b0001 << d);
            check($sformatf("%s c%0d an", name, e), an0, ea);
            check($sformatf("%s c%0d an hex", name, e), an1, ea);
            if (c != 0) begin
                check($sformatf("%s c%0d seg", name, e), seg0, exp_dec[d*7 +: 7]);
                check($sformatf("%s c%0d seg hex", name, e), seg1, exp_hex[d*7 +: 7]);
                check($sformatf("%s c%0d dp", name, e), dp0, exp_dp_n[d]);
            end
            if (e == la || e == lb || e == lc)
                check($sformatf("%s c%0d load_pending", name, e), lp0, 1'b1);
            if (e == 8) check($sformatf("%s c8 frame_done", name), fd0, 1'b0);
            if (e == 16) begin
                check($sformatf("%s c16 frame_done", name), fd0, 1'b1);
                check($sformatf("%s c16 frame_done hex", name), fd1, 1'b1);
                check($sformatf("%s c16 load_pending", name), lp0,
                      (la == 16) || (lb == 16) || (lc == 16));
            end
        end
        load = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; load = 1'b1; digits_in = 16'hFFFF; dp_in = 4'hF; blank_lz = 1'b0;
        step();
        step();
        check_reset_outputs("reset");
        rst = 1'b0; load = 1'b0; dp_in = 4'h0;

        // Idle scan of an all-zero display, then a mid-frame load of 1234.
        run_frame("A", {4{7'h40}}, {4{7'h40}}, 4'hF, 0, 0, 0, 0, 0, 0, 4'h0);
        run_frame("B", {4{7'h40}}, {4{7'h40}}, 4'hF, 6, 16'h1234, 0, 0, 0, 0, 4'b0001);
        run_frame("C", {7'h79, 7'h24, 7'h30, 7'h19}, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1110,
                  3, 16'h00AF, 0, 0, 0, 0, 4'b0100);

        // 00AF with leading-zero blanking; dp on blanked digit 2 still lit.
        blank_lz = 1'b1;
        run_frame("D", {4{7'h7F}}, {7'h7F, 7'h7F, 7'h08, 7'h0E}, 4'b1011,
                  4, 16'h1111, 9, 16'h2222, 16, 16'h3333, 4'h0);
        run_frame("E", {4{7'h24}}, {4{7'h24}}, 4'hF, 0, 0, 0, 0, 0, 0, 4'h0);
        run_frame("F", {4{7'h30}}, {4{7'h30}}, 4'hF, 0, 0, 0, 0, 0, 0, 4'h0);

        // Pause scanning mid-slot for 10 cycles, loading 7890 while paused.
        for (int e = 1; e <= 6; e++) step();
        check("pre-pause an", an0, 4'b1101);
        check("pre-pause seg", seg0, 7'h30);
        en = 1'b0; load = 1'b1; digits_in = 16'h7890; dp_in = 4'b1000;
        for (int k = 0; k < 10; k++) begin
            step();
            load = 1'b0;
            check($sformatf("pause k%0d an", k), an0, 4'hF);
            check($sformatf("pause k%0d seg", k), seg0, 7'h7F);
            check($sformatf("pause k%0d dp", k), dp0, 1'b1);
            check($sformatf("pause k%0d frame_done", k), fd0, 1'b0);
        end
        check("pause load_pending", lp0, 1'b1);
        en = 1'b1;
        step();
        check("resume an", an0, 4'b1101);
        check("resume seg", seg0, 7'h30);
        for (int k = 0; k < 8; k++) step();
        check("resume pre-wrap frame_done", fd0, 1'b0);
        step();
        check("resume wrap frame_done", fd0, 1'b1);
        check("resume wrap load_pending", lp0, 1'b0);

        run_frame("G", {7'h78, 7'h00, 7'h10, 7'h40}, {7'h78, 7'h00, 7'h10, 7'h40}, 4'b0111,
                  5, 16'hBCDE, 0, 0, 0, 0, 4'h0);
        run_frame("H", {4{7'h7F}}, {7'h03, 7'h46, 7'h21, 7'h06}, 4'hF,
                  5, 16'h0560, 0, 0, 0, 0, 4'h0);
        run_frame("I", {7'h7F, 7'h12, 7'h02, 7'h40}, {7'h7F, 7'h12, 7'h02, 7'h40}, 4'hF,
                  0, 0, 0, 0, 0, 0, 4'h0);

        // Reset mid-frame with a load pending; rst also wins over a simultaneous load.
        digits_in = 16'h9999; dp_in = 4'hF;
        for (int e = 1; e <= 5; e++) begin
            load = (e == 2);
            step();
            if (e == 2) check("pre-reset load_pending", lp0, 1'b1);
        end
        load = 1'b1; rst = 1'b1;
        step();
        check_reset_outputs("mid-frame reset");
        rst = 1'b0; load = 1'b0; dp_in = 4'h0;
        run_frame("J", {7'h7F, 7'h7F, 7'h7F, 7'h40}, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF,
                  0, 0, 0, 0, 0, 0, 4'h0);
        blank_lz = 1'b0;
        run_frame("K", {4{7'h40}}, {4{7'h40}}, 4'hF, 0, 0, 0, 0, 0, 0, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_driver.md
SEVEN_SEG_SCAN_DRIVER -- requirements
Module: seven_seg_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (2..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 100000, clk cycles per digit slot (>= BLANK_CYC+2).
REQ-003 SHALL have parameter BLANK_CYC, default 2, anti-ghost cycles at slot start with all anodes off.
REQ-004 SHALL have parameter HEX_MODE, default 0, 1 enables A-F glyphs.
REQ-005 SHALL have one clock and one reset: clk, input, 1, rising-edge clock; rst, input, 1, synchronous, active-high reset.
REQ-006 SHALL have port digits_in, input, 4*NUM_DIGITS, nibble i = digit i, digit 0 rightmost.
REQ-007 SHALL have port dp_in, input, NUM_DIGITS, active-high decimal point per digit.
REQ-008 SHALL have port load, input, 1, request to capture digits_in/dp_in.
REQ-009 SHALL have port en, input, 1, scan enable.
REQ-010 SHALL have port blank_lz, input, 1, leading-zero suppression enable.
REQ-011 SHALL have port an, output, NUM_DIGITS, active-low anodes.
REQ-012 SHALL have port seg, output, 7, active-low segments, bit order gfedcba.
REQ-013 SHALL have port dp, output, 1, active-low decimal point.
REQ-014 SHALL have port frame_done, output, 1, one-cycle pulse at frame end.
REQ-015 SHALL have port load_pending, output, 1, high while a captured value awaits commit.

Function
REQ-016 SHALL keep a prescaler counting 0..REFRESH_DIV-1 and a digit index counting 0..NUM_DIGITS-1, advancing the index when the prescaler wraps; both wrap to 0.
REQ-017 SHALL, on load=1, copy digits_in/dp_in into a pending register and set load_pending the next cycle; a later load before commit overwrites pending (last wins).
REQ-018 SHALL commit pending to the display register on the cycle the index wraps from NUM_DIGITS-1 to 0, clearing load_pending; load in that same cycle is captured into pending and load_pending stays 1.
REQ-019 SHALL pulse frame_done for exactly one cycle on each index wrap to 0.
REQ-020 SHALL decode the selected nibble: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-021 SHALL, with HEX_MODE=1, decode A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110; with HEX_MODE=0, 10..15 SHALL give 1111111.
REQ-022 SHALL, with blank_lz=1, force seg=1111111 for digit i>0 when digit i and all higher digits are 0; digit 0 is never suppressed; dp is unaffected.
REQ-023 SHALL drive an with only bit [index] low, except all ones while prescaler < BLANK_CYC.
REQ-024 SHALL register an, seg, dp: outputs reflect prescaler/index/display state one cycle earlier.
REQ-025 SHALL, with en=0, hold prescaler and index, drive an all ones, seg=1111111, dp=1, suppress frame_done, and still accept load (commit waits for next wrap under en=1).

Reset
REQ-026 SHALL, while rst=1 at a clk edge, clear prescaler, index, display, pending, load_pending, frame_done, and set an all ones, seg=1111111, dp=1; rst dominates load and en.
REQ-027 SHALL discard any pending load on reset mid-frame; first frame after reset shows all zeros (with blank_lz=1: only digit 0 shows 0).

Verification (NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYC=1)
REQ-028 Reset then en=1, no load -> an sequence 1111,1110,1111,1101,...; seg=1000000 on lit slots; frame_done every 16 cycles.
REQ-029 load with digits_in=16'h1234 mid-frame -> load_pending=1 until wrap; next frame digit 3..0 seg=1111001,0100100,0110000,0011001.
REQ-030 HEX_MODE=0 vs 1, digits_in=16'h00AF, blank_lz=1 -> digits 3,2 blank; digits 1,0 show 1111111 (mode 0) or 0001000,0001110 (mode 1).
REQ-031 Two loads (16'h1111 then 16'h2222) before wrap, plus load on wrap cycle (16'h3333) -> 2222 displayed, load_pending stays 1, 3333 shown next frame.
REQ-032 en=0 mid-slot for 10 cycles -> an=1111, seg=1111111, counters frozen; en=1 resumes same slot and prescaler count.
REQ-033 rst asserted mid-frame with load_pending=1 -> next cycle all outputs at reset values; subsequent frame shows 0000.
